i2c_slave_regfile: RTL and testbench
====================================

# i2c_slave_regfile

Parametrised I2C target with an addressable register file, successor to the single-byte write-only I2C slave. It performs 7-bit address matching with real ACK/NACK. Writes set a register pointer and auto-increment through `NUM_REGS` byte registers. Reads (including repeated-START combined transfers) return register contents. It sits on the shared SCL/SDA bus next to the I2C master and exposes the register file to local logic.

## Interface
- `SLV_ADDR`, 7'h50, 7-bit target address compared against the first byte.
- `NUM_REGS`, 4, number of 8-bit registers (2..256). `IDX_W` = max(1, $clog2(NUM_REGS)).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `SCL`  in  1  bus clock from master; target never stretches.
- `SDA`  inout  1  open-drain data. Driven only as 0 when the drive enable is high, else `1'bz`.
- `regs`  out  8*NUM_REGS  flattened register file; reg *i* at bits [8i+7:8i].
- `wr_strobe`  out  1  one-cycle pulse when a data byte is committed to a register.
- `wr_index`  out  IDX_W  index written; valid with `wr_strobe`.
- `busy`  out  1  high from an addressed START (address match) until STOP.

## Operation
- SCL and SDA pass through 2-flop synchronisers; edge and condition detection uses the synchronised values plus a one-cycle-delayed copy.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- STOP, from any state, goes to IDLE, releases SDA and clears `busy`.
- START, from any state including mid-byte (repeated START), goes to ADDR with the bit counter cleared.
- Data is sampled on the SCL rising edge and shifted MSB first. The target changes SDA only on SCL falling edges.
- IDLE: SDA released; wait for START.
- ADDR: shift 8 bits (7 address + R/W).
  - On a match, go to ACK with drive low.
  - On a mismatch, go to IGNORE and never drive SDA.
- ACK: drive SDA low from the SCL falling edge after bit 8 until the next SCL falling edge (the 9th clock). The next state depends on the preceding byte:
  - address+W goes to PTR.
  - address+R loads `regs[ptr]` into the shifter and goes to RDATA.
  - A valid pointer byte goes to WDATA.
  - A data byte goes to WDATA.
- PTR: shift 8 bits.
  - Value < NUM_REGS: load `ptr` and ACK.
  - Otherwise NACK (SDA released in the 9th clock), leave `ptr` unchanged, go to IGNORE.
- WDATA: shift 8 bits. On the 8th SCL rising edge, write `regs[ptr]`, pulse `wr_strobe` with `wr_index`=ptr, increment `ptr`, then ACK.
- RDATA: drive the shifter MSB on each SCL falling edge (drive low for 0, release for 1) for 8 bits. Release SDA for the 9th clock and sample the master's bit on its rising edge.
  - 0 (ACK): increment `ptr`, load the next register, stay in RDATA.
  - 1 (NACK): go to IGNORE.
- IGNORE: SDA released; only START or STOP leave this state.
- Pointer increment wraps: NUM_REGS-1 goes to 0.
- The pointer persists across transactions until rewritten or reset.

## Timing
- Reset values: SDA released, `regs`=0, `ptr`=0, `wr_strobe`=0, `wr_index`=0, `busy`=0, state IDLE, synchronisers = 1.
- Reset is asynchronous and active-low. Assertion mid-transfer releases SDA immediately, without waiting for a clock.
- Detection latency is 3 `clk` from a pin change to the internal edge/condition event. SDA drive changes 1 `clk` after the detected SCL falling edge.
- Bus requirement: SCL high and low phases are each ≥ 8 `clk`. The master holds SDA ≥ 4 `clk` after SCL falls.
- `wr_strobe` is exactly 1 cycle wide, asserted 1 cycle after the 8th detected SCL rising edge of a data byte. `regs` updates in the same cycle.
- `busy` rises 1 cycle after the address-match decision and falls 1 cycle after STOP detection.
- START and STOP in the same detection cycle are impossible on a legal bus. If SCL is sampled low, no condition is decoded.

## Test plan
- Basic write (SLV_ADDR=7'h50, NUM_REGS=4):
  - Stimulus: START, 0xA0, 0x01, 0x11, 0x22, 0x33, STOP.
  - Response: SDA low in all five 9th clocks; `regs[1..3]`=11/22/33; `wr_strobe` pulses 3× with `wr_index` 1,2,3; `busy` 1→0 after STOP.
- Pointer wrap:
  - Stimulus: START, 0xA0, 0x03, 0xAA, 0xBB, STOP.
  - Response: `regs[3]`=0xAA, `regs[0]`=0xBB, all ACKed.
- Address mismatch:
  - Stimulus: START, 0xA2, 0x00, 0x55, STOP.
  - Response: SDA never driven; `regs` unchanged; `wr_strobe` never pulses; `busy` stays 0.
- Combined read (after the basic write):
  - Stimulus: START, 0xA0, 0x02, repeated START, 0xA1; master ACKs byte 1 and NACKs byte 2; STOP.
  - Response: target returns 0x22 then 0x33 and releases SDA after the NACK.
- Invalid pointer:
  - Stimulus: START, 0xA0, 0x07, 0x99, STOP.
  - Response: address ACKed, pointer NACKed (SDA high in 9th clock); 0x99 ignored; `regs` unchanged.
- Reset mid-transfer:
  - Stimulus: drive `rst`=0 during bit 4 of a read byte.
  - Response: SDA released the same cycle; `regs`=0, `busy`=0. After `rst`=1, a fresh basic write completes correctly.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file: 7-bit address match with ACK/NACK,
// a writable register pointer with auto-increment, and combined-format reads.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR = 7'h50,
    parameter int         NUM_REGS = 4,
    localparam int        IDX_W    = ($clog2(NUM_REGS) > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SCL,
    inout  wire                     SDA,
    output logic [8*NUM_REGS-1:0]   regs,
    output logic                    wr_strobe,
    output logic [IDX_W-1:0]        wr_index,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK, S_PTR, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    logic             scl_s1_q, scl_s2_q, scl_dly_q;
    logic             sda_s1_q, sda_s2_q, sda_dly_q;
    state_t           state_q, state_d, nxt_q, nxt_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       sr_q, sr_d;
    logic             drive_q, drive_d;
    logic             ack_hi_q, ack_hi_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             busy_q, busy_d;
    logic             strobe_q, strobe_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic             wr_en;
    logic [7:0]       regs_q [NUM_REGS];

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    assign scl_rise  = scl_s2_q & ~scl_dly_q;
    assign scl_fall  = ~scl_s2_q & scl_dly_q;
    assign start_det = scl_s2_q & scl_dly_q & sda_dly_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_dly_q & ~sda_dly_q & sda_s2_q;
    assign byte_in   = {sr_q[6:0], sda_s2_q};
    assign ptr_inc   = (ptr_q == IDX_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    assign SDA       = drive_q ? 1'b0 : 1'bz;
    assign wr_strobe = strobe_q;
    assign wr_index  = widx_q;
    assign busy      = busy_q;

    // Flatten the register file onto the output bus
    always_comb begin
        regs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[8*i +: 8] = regs_q[i];
        end
    end

    // Bus synchronisers, delayed copies and FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            scl_dly_q <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
            sda_dly_q <= 1'b1;
            state_q   <= S_IDLE;
            nxt_q     <= S_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            drive_q   <= 1'b0;
            ack_hi_q  <= 1'b0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            widx_q    <= '0;
        end else begin
            scl_s1_q  <= SCL;
            scl_s2_q  <= scl_s1_q;
            scl_dly_q <= scl_s2_q;
            sda_s1_q  <= SDA;
            sda_s2_q  <= sda_s1_q;
            sda_dly_q <= sda_s2_q;
            state_q   <= state_d;
            nxt_q     <= nxt_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            drive_q   <= drive_d;
            ack_hi_q  <= ack_hi_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            widx_q    <= widx_d;
        end
    end

    // Register file storage, written when a data byte completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

    // Next-state logic: STOP and START override every state
    always_comb begin
        state_d  = state_q;
        nxt_d    = nxt_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        drive_d  = drive_q;
        ack_hi_d = ack_hi_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        strobe_d = 1'b0;
        widx_d   = widx_q;
        wr_en    = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
            drive_d = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (start_det) begin
            state_d = S_ADDR;
            drive_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (scl_rise) begin
                        sr_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d    = '0;
                            ack_hi_d = 1'b0;
                            state_d  = S_ACK;
                            nxt_d    = S_WDATA;
                            if (state_q == S_ADDR) begin
                                if (byte_in[7:1] == SLV_ADDR) begin
                                    busy_d = 1'b1;
                                    nxt_d  = byte_in[0] ? S_RDATA : S_PTR;
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else if (state_q == S_PTR) begin
                                if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                                    ptr_d = byte_in[IDX_W-1:0];
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end else begin
                                wr_en    = 1'b1;
                                strobe_d = 1'b1;
                                widx_d   = ptr_q;
                                ptr_d    = ptr_inc;
                            end
                        end
                    end
                end
                // Drive low from the fall after bit 8 until the fall ending the 9th clock;
                // a read starts presenting its first bit on that same closing fall.
                S_ACK: begin
                    if (scl_fall) begin
                        if (!ack_hi_q) begin
                            drive_d  = 1'b1;
                            ack_hi_d = 1'b1;
                        end else begin
                            state_d = nxt_q;
                            cnt_d   = '0;
                            drive_d = 1'b0;
                            if (nxt_q == S_RDATA) begin
                                sr_d    = regs_q[ptr_q];
                                drive_d = ~regs_q[ptr_q][7];
                            end
                        end
                    end
                end
                // cnt counts rising edges of the byte; 8 means the 9th clock (master ACK/NACK)
                S_RDATA: begin
                    if (scl_rise) begin
                        if (cnt_q == 4'd8) begin
                            cnt_d = '0;
                            if (!sda_s2_q) begin
                                ptr_d = ptr_inc;
                                sr_d  = regs_q[ptr_inc];
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            drive_d = 1'b0;
                        end else if (cnt_q == 4'd0) begin
                            drive_d = ~sr_q[7];
                        end else begin
                            sr_d    = {sr_q[6:0], 1'b0};
                            drive_d = ~sr_q[6];
                        end
                    end
                end
                default: begin
                    drive_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged I2C master with immediate assertions.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        scl = 1'b1;
    logic        tb_oe = 1'b0;
    wire         sda_bus;
    logic [31:0] regs;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    int          tests = 0;
    int          fails = 0;
    int          strobe_cnt = 0;
    int          wide_cnt = 0;
    logic [31:0] idx_hist = '0;
    logic        prev_st = 1'b0;
    logic        low_seen = 1'b0;
    logic        ack;
    logic [7:0]  rd;

    pullup (sda_bus);
    assign sda_bus = tb_oe ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regfile #(.SLV_ADDR(7'h50), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus),
        .regs(regs), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    // Record strobe pulses/indices and any low level on SDA the bench did not cause
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt++;
            idx_hist = {idx_hist[29:0], wr_index};
            if (prev_st) wide_cnt++;
        end
        prev_st = wr_strobe;
        if (!tb_oe && sda_bus === 1'b0) low_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        strobe_cnt = 0;
        wide_cnt   = 0;
        idx_hist   = '0;
        low_seen   = 1'b0;
    endtask

    task automatic bus_start();
        tb_oe = 1'b0; scl = 1'b1; clks(20);
        tb_oe = 1'b1; clks(20);
        scl = 1'b0;
    endtask

    task automatic bus_rstart();
        clks(10); tb_oe = 1'b0;
        clks(10); scl = 1'b1;
        clks(20); tb_oe = 1'b1;
        clks(20); scl = 1'b0;
    endtask

    task automatic bus_stop();
        clks(10); tb_oe = 1'b1;
        clks(10); scl = 1'b1;
        clks(20); tb_oe = 1'b0;
        clks(20);
    endtask

    task automatic send_bit(input logic b);
        clks(10); tb_oe = ~b;
        clks(10); scl = 1'b1;
        clks(20); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        clks(10); tb_oe = 1'b0;
        clks(10); scl = 1'b1;
        clks(10); a = sda_bus;
        clks(10); scl = 1'b0;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            clks(20); scl = 1'b1;
            clks(10); d[i] = sda_bus;
            clks(10); scl = 1'b0;
        end
        clks(10); tb_oe = mack;
        clks(10); scl = 1'b1;
        clks(20); scl = 1'b0;
        clks(2);  tb_oe = 1'b0;
    endtask

    // Hard time limit so a stuck bus can never hang the run
    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        clks(5);
        chk("rst_regs", regs, 32'h0);
        chk("rst_strobe", 32'(wr_strobe), 32'h0);
        chk("rst_index", 32'(wr_index), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_sda", 32'(sda_bus), 32'h1);
        rst = 1'b1;
        clks(5);

        // Basic write: ptr=1, data 11 22 33
        clear_mon();
        bus_start();
        write_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'h0);
        chk("wr_busy_on", 32'(busy), 32'h1);
        write_byte(8'h01, ack); chk("wr_ptr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack); chk("wr_d0_ack", 32'(ack), 32'h0);
        write_byte(8'h22, ack); chk("wr_d1_ack", 32'(ack), 32'h0);
        write_byte(8'h33, ack); chk("wr_d2_ack", 32'(ack), 32'h0);
        bus_stop();
        clks(5);
        chk("wr_busy_off", 32'(busy), 32'h0);
        chk("wr_regs", regs, 32'h3322_1100);
        chk("wr_strobes", 32'(strobe_cnt), 32'd3);
        chk("wr_indices", idx_hist, 32'h1B);
        chk("wr_strobe_width", 32'(wide_cnt), 32'd0);

        // Combined read from register 2
        bus_start();
        write_byte(8'hA0, ack); chk("rd_addrw_ack", 32'(ack), 32'h0);
        write_byte(8'h02, ack); chk("rd_ptr_ack", 32'(ack), 32'h0);
        bus_rstart();
        write_byte(8'hA1, ack); chk("rd_addrr_ack", 32'(ack), 32'h0);
        read_byte(1'b1, rd); chk("rd_byte0", 32'(rd), 32'h22);
        read_byte(1'b0, rd); chk("rd_byte1", 32'(rd), 32'h33);
        chk("rd_released", 32'(sda_bus), 32'h1);
        bus_stop();
        clks(5);

        // Pointer wrap: 3 -> 0
        clear_mon();
        bus_start();
        write_byte(8'hA0, ack); chk("wrap_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h03, ack); chk("wrap_ptr_ack", 32'(ack), 32'h0);
        write_byte(8'hAA, ack); chk("wrap_d0_ack", 32'(ack), 32'h0);
        write_byte(8'hBB, ack); chk("wrap_d1_ack", 32'(ack), 32'h0);
        bus_stop();
        clks(5);
        chk("wrap_regs", regs, 32'hAA22_11BB);
        chk("wrap_strobes", 32'(strobe_cnt), 32'd2);
        chk("wrap_indices", idx_hist, 32'hC);

        // Address mismatch
        clear_mon();
        bus_start();
        write_byte(8'hA2, ack); chk("mis_addr_nack", 32'(ack), 32'h1);
        chk("mis_busy", 32'(busy), 32'h0);
        write_byte(8'h00, ack); chk("mis_ptr_nack", 32'(ack), 32'h1);
        write_byte(8'h55, ack); chk("mis_data_nack", 32'(ack), 32'h1);
        bus_stop();
        clks(5);
        chk("mis_regs", regs, 32'hAA22_11BB);
        chk("mis_strobes", 32'(strobe_cnt), 32'd0);
        chk("mis_never_driven", 32'(low_seen), 32'h0);
        chk("mis_busy_end", 32'(busy), 32'h0);

        // Invalid pointer
        clear_mon();
        bus_start();
        write_byte(8'hA0, ack); chk("inv_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h07, ack); chk("inv_ptr_nack", 32'(ack), 32'h1);
        write_byte(8'h99, ack); chk("inv_data_nack", 32'(ack), 32'h1);
        bus_stop();
        clks(5);
        chk("inv_regs", regs, 32'hAA22_11BB);
        chk("inv_strobes", 32'(strobe_cnt), 32'd0);

        // Reset during bit 4 of a read of register 3 (0xAA, bit 4 is 0)
        bus_start();
        write_byte(8'hA0, ack); chk("rr_addrw_ack", 32'(ack), 32'h0);
        write_byte(8'h03, ack); chk("rr_ptr_ack", 32'(ack), 32'h0);
        bus_rstart();
        write_byte(8'hA1, ack); chk("rr_addrr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 3; i++) begin
            clks(20); scl = 1'b1;
            clks(20); scl = 1'b0;
        end
        clks(10);
        chk("rr_bit4_driven", 32'(sda_bus), 32'h0);
        rst = 1'b0;
        #1;
        chk("rr_sda_release", 32'(sda_bus), 32'h1);
        chk("rr_regs", regs, 32'h0);
        chk("rr_busy", 32'(busy), 32'h0);
        clks(5);
        rst = 1'b1;
        clks(5);
        scl = 1'b1;
        clks(20);

        // Fresh write after reset
        clear_mon();
        bus_start();
        write_byte(8'hA0, ack); chk("fr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h01, ack); chk("fr_ptr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack); chk("fr_d0_ack", 32'(ack), 32'h0);
        write_byte(8'h22, ack); chk("fr_d1_ack", 32'(ack), 32'h0);
        write_byte(8'h33, ack); chk("fr_d2_ack", 32'(ack), 32'h0);
        bus_stop();
        clks(5);
        chk("fr_regs", regs, 32'h3322_1100);
        chk("fr_strobes", 32'(strobe_cnt), 32'd3);
        chk("fr_indices", idx_hist, 32'h1B);
        chk("fr_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
